// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, framing constants and the
// mid-bit helper used by the receive controller.
package uart_pkg;

  localparam int OVERSAMPLING_FACTOR = 16;
  localparam int DATA_BITS_DEF       = 8;

  // Tick index at which the centre of a bit is reached, counting from 0.
  function automatic int half_bit(input int osf);
    return osf / 2 - 1;
  endfunction

  localparam int HALF_BIT = half_bit(OVERSAMPLING_FACTOR);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive-side bundle between the baud generator / serial line and the
// receive controller. The master side drives the strobe and line; the slave
// side (the controller) returns the received byte and status pulses.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);

  logic                 sample_tick;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_done;
  logic                 frame_error;
  logic                 rx_busy;

  modport master (
    output sample_tick,
    output rx,
    input  rx_data,
    input  rx_done,
    input  frame_error,
    input  rx_busy
  );

  modport slave (
    input  sample_tick,
    input  rx,
    output rx_data,
    output rx_done,
    output frame_error,
    output rx_busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make meta and q sample pre-edge values,
    // giving two real flop stages instead of a single collapsed one.
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises rx, qualifies the start bit at
// mid-bit, shifts data in LSB first on 16x oversampling ticks and checks the
// stop bit. A low stop bit parks the FSM until the line returns high.
module uart_rx_ctrl #(
  parameter int DATA_BITS           = uart_pkg::DATA_BITS_DEF,
  parameter int OVERSAMPLING_FACTOR = uart_pkg::OVERSAMPLING_FACTOR
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);

  import uart_pkg::*;

  localparam int TICK_W = $clog2(OVERSAMPLING_FACTOR);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING_FACTOR - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(half_bit(OVERSAMPLING_FACTOR));
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  rx_state_e            state;
  rx_state_e            next_state;
  logic                 rx_s;
  logic                 tick;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done_q;
  logic                 frame_error_q;

  // Control strobes decoded from the state for the datapath.
  logic cnt_clear;
  logic cnt_inc;
  logic bit_clear;
  logic shift_en;
  logic frame_good;
  logic frame_bad;
  logic busy;

  assign tick = bus.sample_tick;

  sync_2ff #(.RESET_VALUE(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; only start detection reacts to non-tick cycles.
  always_comb begin
    // NOTE: default assignment first so every path drives next_state and no
    // latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:       if (!rx_s) next_state = START;
      START:      if (tick && tick_cnt == TICK_MID)
                    next_state = rx_s ? IDLE : DATA;
      DATA:       if (tick && tick_cnt == TICK_LAST && bit_cnt == BIT_LAST)
                    next_state = STOP;
      STOP:       if (tick && tick_cnt == TICK_LAST)
                    next_state = rx_s ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (tick && rx_s) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Output and datapath-control decode.
  always_comb begin
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    bit_clear  = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:       cnt_clear = 1'b1;
      START: begin
        if (tick) begin
          if (tick_cnt == TICK_MID) begin
            cnt_clear = 1'b1;
            bit_clear = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            cnt_clear = 1'b1;
            shift_en  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            cnt_clear  = 1'b1;
            frame_good = rx_s;
            frame_bad  = !rx_s;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      BREAK_WAIT: cnt_clear = 1'b1;
      default:    cnt_clear = 1'b1;
    endcase
  end

  // Counters, shift register, received byte and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      rx_data_q     <= '0;
      rx_done_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_done_q     <= frame_good;
      frame_error_q <= frame_bad;

      if (cnt_clear)    tick_cnt <= '0;
      else if (cnt_inc) tick_cnt <= tick_cnt + TICK_W'(1);

      if (bit_clear)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + BIT_W'(1);

      if (shift_en)   shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (frame_good) rx_data_q <= shift_reg;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_done     = rx_done_q;
  assign bus.frame_error = frame_error_q;
  assign bus.rx_busy     = busy;

endmodule
